// File: rtl/run_ctrl.sv
// run_ctrl: run/step/halt sequencer producing a divided processor clock
// enable, a held processor reset, a saturating pulse counter and a limit.
//
// Ports:
//   CLOCK_50   in   sole clock, all state on its rising edge
//   RESET_N    in   asynchronous active-low reset
//   run_req    in   start/resume request (level)
//   step_req   in   single-step request (level)
//   clr_req    in   clear: restart reset hold, zero counters
//   hlt        in   processor halt indication
//   cpu_ce     out  registered clock enable, one cycle wide
//   cpu_rst_n  out  registered processor reset, active-low
//   state      out  HOLD=0 IDLE=1 RUN=2 STEP=3 HALT=4
//   cycle_cnt  out  issued cpu_ce pulses, saturating
//   limit_hit  out  sticky, MAX_CYCLES pulses issued
//
// Build option: define RUN_CTRL_STEP_EN to enable single-step support.
// Without it step_req is ignored and STEP is never entered.

module run_ctrl #(
    parameter int unsigned DIV         = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MAX_CYCLES  = 0,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             clr_req,
    input  logic             hlt,
    output logic             cpu_ce,
    output logic             cpu_rst_n,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             limit_hit
);

    localparam logic [2:0] S_HOLD = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DW-1:0]    DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [63:0]      LIMIT     = 64'(MAX_CYCLES);

    logic [DW-1:0]    div_q;
    logic [HW-1:0]    hold_q;

    logic [2:0]       state_d;
    logic [DW-1:0]    div_d;
    logic [HW-1:0]    hold_d;
    logic             ce_d;
    logic [CNT_W-1:0] cnt_d;
    logic             limit_d;

    logic             step_go;
    logic             tick;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_limit;

`ifdef RUN_CTRL_STEP_EN
    assign step_go = step_req;
`else
    wire unused_step = step_req;
    assign step_go = 1'b0;
`endif

    // Divider boundary: a pulse issued on this edge is visible next cycle.
    assign tick = (div_q == DIV_LAST);

    // Saturating increment; the counter never wraps.
    assign cnt_inc = (cycle_cnt == CNT_SAT) ? cycle_cnt
                                            : cycle_cnt + CNT_W'(1);

    // The pulse that makes the count equal the limit is still issued.
    assign at_limit = (MAX_CYCLES != 0) && (64'(cnt_inc) == LIMIT);

    always_comb begin
        state_d = state;
        div_d   = div_q;
        hold_d  = hold_q;
        ce_d    = 1'b0;
        cnt_d   = cycle_cnt;
        limit_d = limit_hit;

        unique case (state)
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end

            S_IDLE: begin
                if (run_req) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end else if (step_go) begin
                    state_d = S_STEP;
                    div_d   = '0;
                end
            end

            S_RUN: begin
                // Halt suppresses a pulse falling due on the same edge.
                if (hlt) begin
                    state_d = S_HALT;
                end else if (tick) begin
                    ce_d  = 1'b1;
                    cnt_d = cnt_inc;
                    div_d = '0;
                    if (at_limit) begin
                        limit_d = 1'b1;
                        state_d = S_HALT;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

`ifdef RUN_CTRL_STEP_EN
            S_STEP: begin
                if (tick) begin
                    ce_d    = 1'b1;
                    cnt_d   = cnt_inc;
                    div_d   = '0;
                    state_d = S_IDLE;
                    if (at_limit) begin
                        limit_d = 1'b1;
                        state_d = S_HALT;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`endif

            S_HALT: begin
                if (!limit_hit) begin
                    if (run_req) begin
                        state_d = S_RUN;
                        div_d   = '0;
                    end else if (step_go) begin
                        state_d = S_STEP;
                        div_d   = '0;
                    end
                end
            end

            default: begin
                state_d = S_HOLD;
                hold_d  = '0;
                div_d   = '0;
            end
        endcase

        // Clear overrides everything, including a pulse due this edge.
        if (clr_req) begin
            state_d = S_HOLD;
            hold_d  = '0;
            div_d   = '0;
            ce_d    = 1'b0;
            cnt_d   = '0;
            limit_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_HOLD;
            div_q     <= '0;
            hold_q    <= '0;
            cpu_ce    <= 1'b0;
            cpu_rst_n <= 1'b0;
            cycle_cnt <= '0;
            limit_hit <= 1'b0;
        end else begin
            state     <= state_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            cpu_ce    <= ce_d;
            cpu_rst_n <= (state_d != S_HOLD);
            cycle_cnt <= cnt_d;
            limit_hit <= limit_d;
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed and randomized checks of run_ctrl in three
// configurations against a cycle-level behavioural model.

module tb_run_ctrl;

`ifdef RUN_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run_req = 1'b0;
    logic step_req = 1'b0;
    logic clr_req = 1'b0;
    logic hlt = 1'b0;

    always #5 clk = ~clk;

    logic        a_ce, a_rstn, a_lim;
    logic [2:0]  a_state;
    logic [31:0] a_cnt;
    logic        b_ce, b_rstn, b_lim;
    logic [2:0]  b_state;
    logic [31:0] b_cnt;
    logic        c_ce, c_rstn, c_lim;
    logic [2:0]  c_state;
    logic [7:0]  c_cnt;

    run_ctrl #(.DIV(4), .CNT_W(32), .MAX_CYCLES(0), .HOLD_CYCLES(8)) u_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .run_req(run_req),
        .step_req(step_req), .clr_req(clr_req), .hlt(hlt),
        .cpu_ce(a_ce), .cpu_rst_n(a_rstn), .state(a_state),
        .cycle_cnt(a_cnt), .limit_hit(a_lim)
    );

    run_ctrl #(.DIV(2), .CNT_W(32), .MAX_CYCLES(10), .HOLD_CYCLES(3)) u_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .run_req(run_req),
        .step_req(step_req), .clr_req(clr_req), .hlt(hlt),
        .cpu_ce(b_ce), .cpu_rst_n(b_rstn), .state(b_state),
        .cycle_cnt(b_cnt), .limit_hit(b_lim)
    );

    run_ctrl #(.DIV(1), .CNT_W(8), .MAX_CYCLES(0), .HOLD_CYCLES(2)) u_c (
        .CLOCK_50(clk), .RESET_N(rst_n), .run_req(run_req),
        .step_req(step_req), .clr_req(clr_req), .hlt(hlt),
        .cpu_ce(c_ce), .cpu_rst_n(c_rstn), .state(c_state),
        .cycle_cnt(c_cnt), .limit_hit(c_lim)
    );

    // Model: mode uses the published state codes; pulses fall on every
    // multiple of the divide ratio counted from entry into RUN/STEP.
    typedef struct {
        int              mode;
        int              since;
        int              hold;
        longint unsigned cnt;
        bit              lim;
        bit              ce;
        bit              rstn;
    } mdl_t;

    mdl_t m_a, m_b, m_c;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pulses_b = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = 0; m.since = 0; m.hold = 0;
        m.cnt = 0; m.lim = 0; m.ce = 0; m.rstn = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(
        mdl_t m, int dv, longint unsigned maxc,
        longint unsigned sat, int holdc,
        bit run, bit stp, bit clr, bit h
    );
        mdl_t n;
        bit   fire;
        n = m;
        fire = 1'b0;
        n.ce = 1'b0;
        if (clr) begin
            n = mdl_reset();
        end else begin
            case (m.mode)
                0: begin
                    n.hold = m.hold + 1;
                    if (n.hold >= holdc) begin
                        n.mode = 1;
                        n.hold = 0;
                    end
                end
                1, 4: begin
                    if (!m.lim) begin
                        if (run) begin
                            n.mode = 2; n.since = 0;
                        end else if (stp && STEP_EN) begin
                            n.mode = 3; n.since = 0;
                        end
                    end
                end
                2: begin
                    if (h) begin
                        n.mode = 4;
                    end else begin
                        n.since = m.since + 1;
                        fire = (n.since % dv == 0);
                    end
                end
                3: begin
                    n.since = m.since + 1;
                    if (n.since % dv == 0) begin
                        fire = 1'b1;
                        n.mode = 1;
                    end
                end
                default: n = mdl_reset();
            endcase
        end
        if (fire) begin
            n.ce = 1'b1;
            n.cnt = (m.cnt >= sat) ? sat : m.cnt + 1;
            if (maxc != 0 && n.cnt == maxc) begin
                n.lim = 1'b1;
                n.mode = 4;
            end
        end
        n.rstn = (n.mode != 0);
        return n;
    endfunction

    function automatic logic [69:0] pack_m(mdl_t m);
        return {3'(m.mode), m.ce, m.rstn, m.lim, m.cnt};
    endfunction

    function automatic logic [69:0] act_a();
        return {a_state, a_ce, a_rstn, a_lim, 64'(a_cnt)};
    endfunction

    function automatic logic [69:0] act_b();
        return {b_state, b_ce, b_rstn, b_lim, 64'(b_cnt)};
    endfunction

    function automatic logic [69:0] act_c();
        return {c_state, c_ce, c_rstn, c_lim, 64'(c_cnt)};
    endfunction

    task automatic models_reset();
        m_a = mdl_reset();
        m_b = mdl_reset();
        m_c = mdl_reset();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_a = mdl_next(m_a, 4, 0, 64'hFFFF_FFFF, 8,
                           run_req, step_req, clr_req, hlt);
            m_b = mdl_next(m_b, 2, 10, 64'hFFFF_FFFF, 3,
                           run_req, step_req, clr_req, hlt);
            m_c = mdl_next(m_c, 1, 0, 64'hFF, 2,
                           run_req, step_req, clr_req, hlt);
        end
        @(negedge clk);
        if (b_ce) pulses_b++;
    endtask

    task automatic test_reset();
        models_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (act_a() !== pack_m(mdl_reset())) begin
            n_fail++;
            $display("FAIL reset_a got %h want %h", act_a(), pack_m(mdl_reset()));
        end
        n_tests++;
        if (act_b() !== pack_m(mdl_reset())) begin
            n_fail++;
            $display("FAIL reset_b got %h want %h", act_b(), pack_m(mdl_reset()));
        end
        n_tests++;
        if (act_c() !== pack_m(mdl_reset())) begin
            n_fail++;
            $display("FAIL reset_c got %h want %h", act_c(), pack_m(mdl_reset()));
        end
    endtask

    task automatic test_run_div4();
        int pulses;
        rst_n = 1'b1;
        run_req = 1'b1;
        repeat (7) tick();
        n_tests++;
        if (a_rstn !== 1'b0 || a_state !== 3'd0) begin
            n_fail++;
            $display("FAIL hold_low got rstn=%b st=%0d want 0 0", a_rstn, a_state);
        end
        tick();
        n_tests++;
        if (a_rstn !== 1'b1 || a_state !== 3'd1) begin
            n_fail++;
            $display("FAIL hold_rel got rstn=%b st=%0d want 1 1", a_rstn, a_state);
        end
        tick();
        n_tests++;
        if (a_state !== 3'd2 || a_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL run_entry got st=%0d ce=%b want 2 0", a_state, a_ce);
        end
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (a_ce) pulses++;
            n_tests++;
            if (a_ce !== (k % 4 == 0)) begin
                n_fail++;
                $display("FAIL div4_ce k=%0d got %b want %b", k, a_ce, (k % 4 == 0));
            end
        end
        n_tests++;
        if (a_cnt !== 32'd5 || pulses != 5) begin
            n_fail++;
            $display("FAIL div4_cnt got %0d/%0d want 5/5", a_cnt, pulses);
        end
    endtask

    task automatic test_hlt();
        longint unsigned frozen;
        frozen = m_c.cnt;
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        run_req = 1'b0;
        n_tests++;
        if (c_state !== 3'd4 || c_ce !== 1'b0 || c_cnt !== 8'(frozen)) begin
            n_fail++;
            $display("FAIL hlt_edge got st=%0d ce=%b cnt=%0d want 4 0 %0d",
                     c_state, c_ce, c_cnt, frozen);
        end
        tick();
        n_tests++;
        if (c_state !== 3'd4 || c_ce !== 1'b0 || c_cnt !== 8'(frozen)) begin
            n_fail++;
            $display("FAIL hlt_hold got st=%0d ce=%b cnt=%0d want 4 0 %0d",
                     c_state, c_ce, c_cnt, frozen);
        end
    endtask

    task automatic test_limit();
        run_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (b_ce !== 1'b0 || b_state !== 3'd4) begin
                n_fail++;
                $display("FAIL limit_stay k=%0d got ce=%b st=%0d want 0 4", k, b_ce, b_state);
            end
        end
        n_tests++;
        if (b_lim !== 1'b1 || b_cnt !== 32'd10 || pulses_b != 10) begin
            n_fail++;
            $display("FAIL limit_end got lim=%b cnt=%0d pulses=%0d want 1 10 10",
                     b_lim, b_cnt, pulses_b);
        end
    endtask

    task automatic test_clear();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (a_ce) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL clear_sync got no pulse want pulse within 8");
        end
        repeat (3) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        run_req = 1'b0;
        step_req = 1'b1;
        n_tests++;
        if (act_a() !== pack_m(mdl_reset())) begin
            n_fail++;
            $display("FAIL clear_a got %h want %h", act_a(), pack_m(mdl_reset()));
        end
        n_tests++;
        if (b_lim !== 1'b0 || b_cnt !== 32'd0 || b_state !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_b got lim=%b cnt=%0d st=%0d want 0 0 0", b_lim, b_cnt, b_state);
        end
        repeat (7) tick();
        n_tests++;
        if (a_state !== 3'd0 || a_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_hold got st=%0d rstn=%b want 0 0", a_state, a_rstn);
        end
        step_req = 1'b0;
        tick();
        n_tests++;
        if (a_state !== 3'd1 || a_rstn !== 1'b1 || a_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_rel got st=%0d rstn=%b ce=%b want 1 1 0", a_state, a_rstn, a_ce);
        end
    endtask

    task automatic test_step();
        logic [2:0]  st_exp;
        logic [31:0] cnt_exp;
        st_exp = STEP_EN ? 3'd3 : 3'd1;
        cnt_exp = STEP_EN ? 32'd1 : 32'd0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        n_tests++;
        if (a_state !== st_exp) begin
            n_fail++;
            $display("FAIL step_entry got %0d want %0d", a_state, st_exp);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (a_ce !== (STEP_EN && k == 4)) begin
                n_fail++;
                $display("FAIL step_ce k=%0d got %b want %b", k, a_ce, (STEP_EN && k == 4));
            end
        end
        n_tests++;
        if (a_cnt !== cnt_exp || a_state !== 3'd1) begin
            n_fail++;
            $display("FAIL step_end got cnt=%0d st=%0d want %0d 1", a_cnt, a_state, cnt_exp);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        seen = 1'b0;
        run_req = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (a_ce) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_sync got no pulse want pulse within 12");
        end
        #2 rst_n = 1'b0;
        models_reset();
        #1;
        n_tests++;
        if (act_a() !== pack_m(mdl_reset())) begin
            n_fail++;
            $display("FAIL rst_async_a got %h want %h", act_a(), pack_m(mdl_reset()));
        end
        n_tests++;
        if (act_c() !== pack_m(mdl_reset())) begin
            n_fail++;
            $display("FAIL rst_async_c got %h want %h", act_c(), pack_m(mdl_reset()));
        end
        tick();
        rst_n = 1'b1;
        run_req = 1'b0;
        repeat (7) tick();
        n_tests++;
        if (a_state !== 3'd0 || a_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold got st=%0d ce=%b want 0 0", a_state, a_ce);
        end
        tick();
        n_tests++;
        if (a_state !== 3'd1 || a_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rel got st=%0d rstn=%b want 1 1", a_state, a_rstn);
        end
    endtask

    task automatic test_saturate();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        run_req = 1'b1;
        repeat (300) tick();
        n_tests++;
        if (c_cnt !== 8'hFF || c_ce !== 1'b1 || c_state !== 3'd2) begin
            n_fail++;
            $display("FAIL saturate got cnt=%0d ce=%b st=%0d want 255 1 2", c_cnt, c_ce, c_state);
        end
        n_tests++;
        if (a_cnt !== 32'd72) begin
            n_fail++;
            $display("FAIL sat_div4 got %0d want 72", a_cnt);
        end
        n_tests++;
        if (b_lim !== 1'b1 || b_cnt !== 32'd10 || b_state !== 3'd4) begin
            n_fail++;
            $display("FAIL sat_limit got lim=%b cnt=%0d st=%0d want 1 10 4", b_lim, b_cnt, b_state);
        end
        run_req = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            run_req  = ($urandom_range(0, 3) != 0);
            step_req = ($urandom_range(0, 2) == 0);
            hlt      = ($urandom_range(0, 9) == 0);
            clr_req  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                models_reset();
                #1;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
            n_tests++;
            if (act_a() !== pack_m(m_a)) begin
                n_fail++;
                $display("FAIL rand_a i=%0d got %h want %h", i, act_a(), pack_m(m_a));
            end
            n_tests++;
            if (act_b() !== pack_m(m_b)) begin
                n_fail++;
                $display("FAIL rand_b i=%0d got %h want %h", i, act_b(), pack_m(m_b));
            end
            n_tests++;
            if (act_c() !== pack_m(m_c)) begin
                n_fail++;
                $display("FAIL rand_c i=%0d got %h want %h", i, act_c(), pack_m(m_c));
            end
        end
        run_req = 1'b0;
        step_req = 1'b0;
        hlt = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_run_div4();
        test_hlt();
        test_limit();
        test_clear();
        test_step();
        test_reset_mid_run();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
